// File: rtl/vga_pixel_feeder_if.sv
// Handshake and image-port bundle between pixel requesters, the feeder and the pixmap image block.
// The master modport is the requester / software side, and the slave modport is the feeder.
interface vga_pixel_feeder_if;
  logic        a_valid;
  logic [11:0] a_rgb;
  logic        a_ready;
  logic        b_valid;
  logic [11:0] b_rgb;
  logic        b_ready;
  logic        clear_req;
  logic        add_input;
  logic [11:0] rgb_code;
  logic        img_reset;
  logic [10:0] cursor;
  logic        frame_done;
  logic        busy;

  modport master (
    output a_valid, a_rgb, b_valid, b_rgb, clear_req,
    input  a_ready, b_ready, add_input, rgb_code, img_reset, cursor, frame_done, busy
  );

  modport slave (
    input  a_valid, a_rgb, b_valid, b_rgb, clear_req,
    output a_ready, b_ready, add_input, rgb_code, img_reset, cursor, frame_done, busy
  );
endinterface

// File: rtl/vga_pixel_feeder.sv
// Round-robin write-side controller for the 40x30 pixmap image block.
// It serialises the pixel writes, sequences frame clears and tracks the write cursor.
module vga_pixel_feeder #(
  parameter int PW         = 40,
  parameter int PH         = 30,
  parameter int HOLD       = 2,
  parameter int GAP        = 1,
  parameter int CLR_CYCLES = 2
) (
  input  logic               clk_50,
  input  logic               reset,
  vga_pixel_feeder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic [10:0] CELLS      = 11'(PW * PH);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(GAP - 1);
  localparam logic [7:0]  CLR_LAST   = 8'(CLR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] rgb_q, rgb_d;
  logic [10:0] cursor_q, cursor_d;
  logic        last_b_q, last_b_d;
  logic        clear_pend_q, clear_pend_d;
  logic        add_q, add_d;
  logic        img_rst_q, img_rst_d;
  logic        fdone_q, fdone_d;
  logic        busy_q, busy_d;

  logic        clear_any;
  logic        grant_a;
  logic        grant_b;
  logic        idle_free;
  logic [10:0] cursor_inc;

  // A same-cycle clear_req already counts as pending, so a clear wins over a pixel offered in that cycle.
  always_comb begin
    clear_any    = clear_pend_q | bus.clear_req;
    grant_a      = bus.a_valid & (~bus.b_valid | last_b_q);
    grant_b      = bus.b_valid & (~bus.a_valid | ~last_b_q);
    idle_free    = (state_q == ST_IDLE) & ~clear_any & ~reset;
    cursor_inc   = cursor_q + 11'd1;
    state_d      = state_q;
    cnt_d        = cnt_q;
    rgb_d        = rgb_q;
    cursor_d     = cursor_q;
    last_b_d     = last_b_q;
    fdone_d      = 1'b0;
    clear_pend_d = clear_pend_q | bus.clear_req;
    case (state_q)
      ST_IDLE: begin
        if (clear_any) begin
          state_d      = ST_CLEAR;
          cnt_d        = 8'd0;
          cursor_d     = 11'd0;
          clear_pend_d = 1'b0;
        end else if (grant_a) begin
          state_d  = ST_WRITE;
          cnt_d    = 8'd0;
          rgb_d    = bus.a_rgb;
          last_b_d = 1'b0;
        end else if (grant_b) begin
          state_d  = ST_WRITE;
          cnt_d    = 8'd0;
          rgb_d    = bus.b_rgb;
          last_b_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_GAP;
          cnt_d   = 8'd0;
          if (cursor_inc == CELLS) begin
            cursor_d = 11'd0;
            fdone_d  = 1'b1;
          end else begin
            cursor_d = cursor_inc;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CLEAR: begin
        cursor_d = 11'd0;
        if (cnt_q == CLR_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    add_d     = (state_d == ST_WRITE);
    img_rst_d = (state_d == ST_CLEAR);
    busy_d    = (state_d != ST_IDLE) | clear_pend_d;
  end

  // State and registered image-port outputs.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      rgb_q        <= 12'd0;
      cursor_q     <= 11'd0;
      last_b_q     <= 1'b1;
      clear_pend_q <= 1'b0;
      add_q        <= 1'b0;
      img_rst_q    <= 1'b0;
      fdone_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rgb_q        <= rgb_d;
      cursor_q     <= cursor_d;
      last_b_q     <= last_b_d;
      clear_pend_q <= clear_pend_d;
      add_q        <= add_d;
      img_rst_q    <= img_rst_d;
      fdone_q      <= fdone_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.a_ready    = idle_free & grant_a;
  assign bus.b_ready    = idle_free & grant_b;
  assign bus.add_input  = add_q;
  assign bus.rgb_code   = rgb_q;
  assign bus.img_reset  = img_rst_q;
  assign bus.cursor     = cursor_q;
  assign bus.frame_done = fdone_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed self-checking bench for vga_pixel_feeder.
// It covers reset, a single write, round-robin, cursor wrap, clear during a write and clear priority.
module tb_vga_pixel_feeder;
  logic clk_50;
  logic reset;
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   cycle_cnt = 0;
  int   fd_count  = 0;
  int   prev_acc;
  bit   ok;

  vga_pixel_feeder_if vif();

  vga_pixel_feeder #(
    .PW(40), .PH(30), .HOLD(2), .GAP(1), .CLR_CYCLES(2)
  ) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (vif)
  );

  initial begin
    clk_50 = 1'b0;
    forever #10 clk_50 = ~clk_50;
  end

  always @(posedge clk_50) cycle_cnt <= cycle_cnt + 1;
  always @(negedge clk_50) if (vif.frame_done === 1'b1) fd_count <= fd_count + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk_50);
    #1;
  endtask

  task automatic wait_ready(output bit found);
    found = 1'b0;
    for (int w = 0; w < 12; w++) begin
      if ((vif.a_ready | vif.b_ready) === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    reset         = 1'b1;
    vif.a_valid   = 1'b1;
    vif.b_valid   = 1'b1;
    vif.a_rgb     = 12'hF0A;
    vif.b_rgb     = 12'h222;
    vif.clear_req = 1'b0;

    // reset held 3 cycles with both requesters valid
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_add", 32'(vif.add_input), 0);
      check_eq("rst_img", 32'(vif.img_reset), 0);
      check_eq("rst_cursor", 32'(vif.cursor), 0);
      check_eq("rst_rgb", 32'(vif.rgb_code), 0);
      check_eq("rst_fdone", 32'(vif.frame_done), 0);
      check_eq("rst_busy", 32'(vif.busy), 0);
      check_eq("rst_ready", 32'({vif.a_ready, vif.b_ready}), 0);
    end
    reset = 1'b0;
    #1;
    check_eq("rst_a_first", 32'(vif.a_ready), 1);
    check_eq("rst_b_wait", 32'(vif.b_ready), 0);

    // single write of 0xF0A
    step();
    vif.a_valid = 1'b0;
    vif.b_valid = 1'b0;
    check_eq("wr_add1", 32'(vif.add_input), 1);
    check_eq("wr_rgb", 32'(vif.rgb_code), 'hF0A);
    check_eq("wr_cursor0", 32'(vif.cursor), 0);
    check_eq("wr_busy", 32'(vif.busy), 1);
    step();
    check_eq("wr_add2", 32'(vif.add_input), 1);
    check_eq("wr_cursor_hold", 32'(vif.cursor), 0);
    step();
    check_eq("wr_gap_add", 32'(vif.add_input), 0);
    check_eq("wr_cursor1", 32'(vif.cursor), 1);
    step();
    check_eq("wr_idle_add", 32'(vif.add_input), 0);
    check_eq("wr_idle_busy", 32'(vif.busy), 0);

    // round-robin after a fresh reset so A wins the first tie
    reset = 1'b1;
    step();
    reset = 1'b0;
    vif.a_rgb   = 12'h111;
    vif.b_rgb   = 12'h222;
    vif.a_valid = 1'b1;
    vif.b_valid = 1'b1;
    #1;
    prev_acc = 0;
    for (int i = 0; i < 6; i++) begin
      wait_ready(ok);
      check_eq("rr_ready", 32'(ok), 1);
      if (i > 0) check_eq("rr_spacing", 32'(cycle_cnt - prev_acc), 4);
      prev_acc = cycle_cnt;
      check_eq("rr_grant", 32'({vif.a_ready, vif.b_ready}), (i % 2 == 0) ? 2 : 1);
      step();
      check_eq("rr_rgb", 32'(vif.rgb_code), (i % 2 == 0) ? 'h111 : 'h222);
    end
    vif.a_valid = 1'b0;
    vif.b_valid = 1'b0;

    // 1200 writes from A wrap the cursor exactly once
    reset = 1'b1;
    step();
    reset = 1'b0;
    vif.a_rgb   = 12'h0F0;
    vif.a_valid = 1'b1;
    #1;
    for (int n = 0; n < 1200; n++) begin
      wait_ready(ok);
      check_eq("wrap_ready", 32'(ok), 1);
      if (n == 1199) begin
        check_eq("wrap_pre_cursor", 32'(vif.cursor), 1199);
        check_eq("wrap_no_fd_yet", 32'(fd_count), 0);
      end
      step();
    end
    vif.a_valid = 1'b0;
    check_eq("wrap_fd_w1", 32'(vif.frame_done), 0);
    step();
    check_eq("wrap_fd_w2", 32'(vif.frame_done), 0);
    check_eq("wrap_cursor_1199", 32'(vif.cursor), 1199);
    step();
    check_eq("wrap_fd_pulse", 32'(vif.frame_done), 1);
    check_eq("wrap_cursor_0", 32'(vif.cursor), 0);
    step();
    check_eq("wrap_fd_end", 32'(vif.frame_done), 0);
    check_eq("wrap_fd_once", 32'(fd_count), 1);

    // clear requested during the second WRITE cycle of the pixel at cursor 5
    vif.a_valid = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_ready(ok);
      step();
    end
    wait_ready(ok);
    check_eq("cmw_ready", 32'(ok), 1);
    check_eq("cmw_cursor5", 32'(vif.cursor), 5);
    step();
    vif.a_valid = 1'b0;
    vif.b_valid = 1'b1;
    vif.b_rgb   = 12'h0B0;
    step();
    vif.clear_req = 1'b1;
    check_eq("cmw_add_w2", 32'(vif.add_input), 1);
    step();
    vif.clear_req = 1'b0;
    #1;
    check_eq("cmw_cursor6", 32'(vif.cursor), 6);
    check_eq("cmw_gap_add", 32'(vif.add_input), 0);
    check_eq("cmw_gap_img", 32'(vif.img_reset), 0);
    check_eq("cmw_gap_bready", 32'(vif.b_ready), 0);
    step();
    check_eq("cmw_pend_bready", 32'(vif.b_ready), 0);
    check_eq("cmw_pend_busy", 32'(vif.busy), 1);
    step();
    check_eq("cmw_img1", 32'(vif.img_reset), 1);
    check_eq("cmw_clr_cursor", 32'(vif.cursor), 0);
    check_eq("cmw_clr_bready", 32'(vif.b_ready), 0);
    step();
    check_eq("cmw_img2", 32'(vif.img_reset), 1);
    check_eq("cmw_clr_fdone", 32'(vif.frame_done), 0);
    step();
    check_eq("cmw_img_off", 32'(vif.img_reset), 0);
    check_eq("cmw_b_granted", 32'(vif.b_ready), 1);
    step();
    vif.b_valid = 1'b0;
    check_eq("cmw_b_rgb", 32'(vif.rgb_code), 'h0B0);
    check_eq("cmw_b_add", 32'(vif.add_input), 1);
    check_eq("cmw_b_cursor0", 32'(vif.cursor), 0);
    step();
    step();
    check_eq("cmw_b_cursor1", 32'(vif.cursor), 1);
    step();
    check_eq("cmw_idle_busy", 32'(vif.busy), 0);

    // clear and a pixel offered in the same IDLE cycle
    vif.clear_req = 1'b1;
    vif.a_valid   = 1'b1;
    vif.a_rgb     = 12'h5A5;
    #1;
    check_eq("cp_a_blocked", 32'(vif.a_ready), 0);
    step();
    vif.clear_req = 1'b0;
    #1;
    check_eq("cp_img1", 32'(vif.img_reset), 1);
    check_eq("cp_a_wait1", 32'(vif.a_ready), 0);
    check_eq("cp_cursor0", 32'(vif.cursor), 0);
    step();
    check_eq("cp_img2", 32'(vif.img_reset), 1);
    check_eq("cp_a_wait2", 32'(vif.a_ready), 0);
    step();
    check_eq("cp_img_off", 32'(vif.img_reset), 0);
    check_eq("cp_a_granted", 32'(vif.a_ready), 1);
    step();
    vif.a_valid = 1'b0;
    check_eq("cp_rgb", 32'(vif.rgb_code), 'h5A5);
    check_eq("cp_add", 32'(vif.add_input), 1);
    check_eq("cp_cursor", 32'(vif.cursor), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
